// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word-aligned imem requests, tracks
// in-flight addresses, buffers returned instructions in a small queue and
// presents the head to the IF/ID stage. Execute-stage redirects flush the
// queue and mark responses already in flight as stale.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ValidF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;
  localparam int unsigned IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fpc;
  logic [1:0]    outstanding;
  logic [1:0]    discard;
  logic [1:0]    outstanding_nxt;
  logic [CW-1:0] occupancy;
  logic [AW-1:0] q_rd;
  logic [AW-1:0] q_wr;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [31:0]   if_pc   [MAX_OUT];
  logic [IW-1:0] if_rd;
  logic [IW-1:0] if_wr;
  logic [SW-1:0] reserved;
  logic          grant;
  logic          rsp_any;
  logic          rsp_drop;
  logic          push;
  logic          pop;

  // In-flight FIFO depth need not be a power of two, so wrap explicitly.
  function automatic logic [IW-1:0] inc_ip(input logic [IW-1:0] p);
    return (p == IW'(MAX_OUT - 1)) ? '0 : p + IW'(1);
  endfunction

  // Queue slots are reserved at request time: a request is only issued when
  // every outstanding response is guaranteed a free queue entry.
  assign reserved  = SW'(outstanding) + SW'(occupancy);
  assign imem_req  = reset && !PCSrcE && (outstanding < 2'(MAX_OUT)) &&
                     (reserved < SW'(DEPTH));
  assign imem_addr = fpc;
  assign grant     = imem_req && imem_gnt;

  // Responses with nothing outstanding (e.g. aborted by reset) are ignored.
  assign rsp_any  = imem_rvalid && (outstanding != 2'd0);
  assign rsp_drop = rsp_any && (discard != 2'd0);
  assign push     = rsp_any && (discard == 2'd0) && (occupancy != CW'(DEPTH));
  assign pop      = ValidF && !StallF && !PCSrcE;

  assign outstanding_nxt = outstanding + 2'(grant) - 2'(rsp_any);

  assign ValidF   = (occupancy != '0);
  assign InstrF   = ValidF ? q_instr[q_rd] : NOP;
  assign PCF      = ValidF ? q_pc[q_rd] : '0;
  assign PCPlus4F = ValidF ? q_pc[q_rd] + 32'd4 : '0;

  // Control state: fetch PC, counters and pointers; redirect overrides pushes/pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc         <= RESET_PC;
      outstanding <= 2'd0;
      discard     <= 2'd0;
      occupancy   <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      if_rd       <= '0;
      if_wr       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (rsp_any) if_rd <= inc_ip(if_rd);
      if (grant)   if_wr <= inc_ip(if_wr);
      if (PCSrcE) begin
        fpc       <= PCTargetE & 32'hFFFF_FFFC;
        discard   <= outstanding_nxt;
        occupancy <= '0;
        q_rd      <= '0;
        q_wr      <= '0;
      end else begin
        if (grant)    fpc     <= fpc + 32'd4;
        if (rsp_drop) discard <= discard - 2'd1;
        if (push)     q_wr    <= q_wr + AW'(1);
        if (pop)      q_rd    <= q_rd + AW'(1);
        occupancy <= occupancy + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage: instruction queue entries and addresses of in-flight requests.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[q_wr] <= imem_rdata;
      q_pc[q_wr]    <= if_pc[if_rd];
    end
    if (grant) if_pc[if_wr] <= fpc;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a queue-based
// reference model of the fetch front end.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        ValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model: queue of delivered instructions, list of in-flight
  // addresses, stale-response count and the next fetch address.
  ent_t        mq[$];
  logic [31:0] minfl[$];
  int          mdisc;
  logic [31:0] mfpc;
  // Memory side: granted addresses with the cycle they were granted.
  logic [31:0] mem_addr[$];
  int          mem_stamp[$];
  int          cyc;
  bit          force_rv;

  int checks;
  int errors;

  logic        s_req, s_val;
  logic [31:0] s_addr, s_instr, s_pcf, s_pc4;

  typedef struct {
    logic        st;
    logic        gnt;
    logic        rv;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pcf;
  } vec_t;
  vec_t tv[21];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic bit pick(input int pct);
    if (pct <= 0) return 1'b0;
    if (pct >= 100) return 1'b1;
    return ($urandom_range(99) < pct);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    minfl.delete();
    mdisc = 0;
    mfpc  = RESET_PC;
    mem_addr.delete();
    mem_stamp.delete();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance
  // the model to the state after the coming posedge, then wait for negedge.
  task automatic cycle(input logic st, input logic br, input logic [31:0] tgt,
                       input int gp, input int rp);
    logic        g, rv, e_req, e_val, keep;
    logic [31:0] rpc;
    ent_t        e;
    g  = pick(gp);
    rv = force_rv || (pick(rp) && mem_addr.size() > 0 && mem_stamp[0] < cyc);
    StallF      = st;
    PCSrcE      = br;
    PCTargetE   = tgt;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = (rv && mem_addr.size() > 0) ? word_of(mem_addr[0]) : $urandom;
    #1;
    s_req = imem_req;  s_addr = imem_addr; s_val = ValidF;
    s_instr = InstrF;  s_pcf = PCF;        s_pc4 = PCPlus4F;
    e_req = reset && !br && (minfl.size() < MAX_OUT) &&
            ((minfl.size() + mq.size()) < DEPTH);
    e_val = (mq.size() > 0);
    chk("imem_req", s_req, e_req);
    chk("imem_addr", s_addr, mfpc);
    chk("ValidF", s_val, e_val);
    chk("InstrF", s_instr, e_val ? mq[0].instr : NOP);
    chk("PCF", s_pcf, e_val ? mq[0].pc : 32'h0);
    chk("PCPlus4F", s_pc4, e_val ? mq[0].pc + 32'd4 : 32'h0);
    if (reset) begin
      if (rv && mem_addr.size() > 0) begin
        void'(mem_addr.pop_front());
        void'(mem_stamp.pop_front());
      end
      keep = 1'b0;
      rpc  = '0;
      if (rv && minfl.size() > 0) begin
        rpc = minfl.pop_front();
        if (mdisc > 0) mdisc--;
        else if (mq.size() < DEPTH) keep = 1'b1;
      end
      if (br) begin
        mq.delete();
        mfpc  = tgt & 32'hFFFF_FFFC;
        mdisc = minfl.size();
      end else begin
        if (e_val && !st) void'(mq.pop_front());
        if (keep) begin
          e.pc = rpc;
          e.instr = imem_rdata;
          mq.push_back(e);
        end
        if (e_req && g) begin
          minfl.push_back(mfpc);
          mem_addr.push_back(mfpc);
          mem_stamp.push_back(cyc);
          mfpc = mfpc + 32'd4;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    model_clear();
    repeat (n) cycle(1'b0, 1'b0, 32'h0, 100, 100);
    reset = 1'b1;
  endtask

  task automatic rand_cycles(input int n);
    repeat (n) cycle(pick(30), pick(5), $urandom, 70, 60);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; force_rv = 1'b0;
    // Steady stream, then a 10-cycle stall, then release.
    tv[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
    tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    tv[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    tv[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
    tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd32, 1'b1, 32'd16};
    for (int i = 9; i < 16; i++) tv[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd32, 1'b1, 32'd16};
    tv[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd32, 1'b1, 32'd16};
    tv[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd32, 1'b1, 32'd20};
    tv[18] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd36, 1'b1, 32'd24};
    tv[19] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd40, 1'b1, 32'd28};
    tv[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'd44, 1'b1, 32'd32};

    model_clear();
    @(negedge clk);
    do_reset(2);
    chk("rst_req", s_req, 1'b0);
    chk("rst_instr", s_instr, NOP);

    for (int i = 0; i < 21; i++) begin
      cycle(tv[i].st, 1'b0, 32'h0, tv[i].gnt ? 100 : 0, tv[i].rv ? 100 : 0);
      chk("tbl_req", s_req, tv[i].e_req);
      chk("tbl_addr", s_addr, tv[i].e_addr);
      chk("tbl_valid", s_val, tv[i].e_val);
      chk("tbl_pcf", s_pcf, tv[i].e_pcf);
      if (tv[i].e_val) chk("tbl_instr", s_instr, word_of(tv[i].e_pcf));
    end

    // Redirect with two requests in flight (0x10, 0x14) and one queued entry.
    do_reset(1);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 100, 100);
    cycle(1'b1, 1'b0, 32'h0, 100, 0);
    chk("redir_pre_addr", s_addr, 32'h14);
    cycle(1'b0, 1'b1, 32'h102, 100, 100);
    chk("redir_req", s_req, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    chk("redir_addr", s_addr, 32'h100);
    chk("redir_req1", s_req, 1'b1);
    chk("redir_valid0", s_val, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    chk("redir_valid1", s_val, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    chk("redir_valid2", s_val, 1'b1);
    chk("redir_pcf", s_pcf, 32'h100);

    // Grant withheld for five cycles: request and address hold.
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 0, 100);
      chk("hold_req", s_req, 1'b1);
      chk("hold_addr", s_addr, RESET_PC);
    end
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    chk("hold_gaddr", s_addr, RESET_PC);
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    chk("hold_next", s_addr, RESET_PC + 32'd4);

    // Address wrap at the top of the address space, misaligned target.
    do_reset(1);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFD, 100, 100);
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    chk("wrap_addr1", s_addr, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 100, 100);
    chk("wrap_pcf", s_pcf, 32'hFFFF_FFFC);
    chk("wrap_pc4", s_pc4, 32'h0);

    // Randomized traffic.
    do_reset(1);
    rand_cycles(2500);

    // Asynchronous reset mid-cycle, then a stray response right after release.
    #2;
    reset = 1'b0;
    #1;
    chk("async_req", imem_req, 1'b0);
    chk("async_valid", ValidF, 1'b0);
    chk("async_instr", InstrF, NOP);
    chk("async_pcf", PCF, 32'h0);
    chk("async_addr", imem_addr, RESET_PC);
    model_clear();
    @(negedge clk);
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    reset = 1'b1;
    force_rv = 1'b1;
    cycle(1'b0, 1'b0, 32'h0, 0, 0);
    force_rv = 1'b0;
    chk("rel_req", s_req, 1'b1);
    chk("rel_addr", s_addr, RESET_PC);
    cycle(1'b0, 1'b0, 32'h0, 100, 100);
    chk("stray_valid", s_val, 1'b0);
    rand_cycles(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning instruction queue entries (power of two, 2..16).
REQ-002 Parameter MAX_OUT, default 2, meaning maximum outstanding imem requests (1..3).
REQ-003 Parameter RESET_PC, default 32'h00000000, meaning first fetch address after reset.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous, active-low reset (reset=0 asserts, acts immediately, independent of clk).
REQ-006 imem_req  out  1  fetch request valid.
REQ-007 imem_addr  out  32  fetch byte address, word aligned.
REQ-008 imem_gnt  in  1  request accepted this cycle when imem_req=1.
REQ-009 imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-010 imem_rdata  in  32  response instruction word.
REQ-011 StallF  in  1  downstream IF/ID register holding; blocks pop.
REQ-012 PCSrcE  in  1  redirect from execute (taken branch or jump).
REQ-013 PCTargetE  in  32  redirect target address.
REQ-014 ValidF  out  1  queue head holds a valid instruction.
REQ-015 InstrF  out  32  head instruction; 32'h00000013 (nop) when ValidF=0.
REQ-016 PCF  out  32  head instruction address; 0 when ValidF=0.
REQ-017 PCPlus4F  out  32  PCF+4 (modulo 2^32); 0 when ValidF=0.

Function
REQ-018 fpc register holds next fetch address; imem_addr SHALL equal fpc.
REQ-019 imem_req SHALL be 1 iff PCSrcE=0 and outstanding<MAX_OUT and (outstanding+occupancy)<DEPTH.
REQ-020 Handshake: imem_req=1 and imem_gnt=1 -> fpc<=fpc+4 (wraps modulo 2^32), outstanding+1, address pushed to in-flight PC FIFO (MAX_OUT deep).
REQ-021 Once imem_req=1 without grant, imem_req and imem_addr SHALL hold stable until grant; the only exception is a PCSrcE=1 cycle.
REQ-022 Response with discard=0: push {imem_rdata, in-flight PC head} into queue, pop in-flight FIFO, outstanding-1.
REQ-023 Response with discard>0: drop data, pop in-flight FIFO, outstanding-1, discard-1.
REQ-024 Pop: ValidF=1 and StallF=0 -> head advances at posedge; ValidF=0 -> StallF ignored.
REQ-025 No bypass: a response written in cycle t SHALL first appear at outputs in cycle t+1, even if the queue is empty; minimum grant-to-ValidF latency is 2 cycles.
REQ-026 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-027 Queue overflow is impossible by REQ-019 reservation; a response arriving while occupancy=DEPTH is a protocol error, and the data SHALL be dropped.
REQ-028 Redirect (PCSrcE=1) at posedge: queue emptied (occupancy 0, ValidF=0 next cycle); fpc<=PCTargetE with bits [1:0] forced to 0; discard<=outstanding after this cycle's response is accounted; no request issued in the redirect cycle.
REQ-029 Redirect with simultaneous pop or response: redirect wins; the pop is lost and the response is accounted (REQ-022/023) before the flush.
REQ-030 New requests are permitted the cycle after redirect while discard>0; in-order return guarantees stale responses arrive first.
REQ-031 Outstanding and discard counters SHALL never exceed MAX_OUT nor underflow; an imem_rvalid with outstanding=0 SHALL be ignored.

Reset
REQ-032 While reset=0: fpc=RESET_PC, occupancy=0, outstanding=0, discard=0, ValidF=0, InstrF=32'h00000013, PCF=0, PCPlus4F=0, imem_req=0.
REQ-033 Reset asserted mid-transaction aborts all in-flight requests; responses arriving in the first MAX_OUT cycles after release with outstanding=0 are ignored.
REQ-034 The first imem_req=1 SHALL occur in the first cycle after reset deasserts, with imem_addr=RESET_PC.

Verification
REQ-035 Reset release, gnt=1 always, 1-cycle response, StallF=0 -> addresses 0,4,8,...; ValidF=1 from cycle 3 with PCF=0, InstrF=first word, PCPlus4F=4.
REQ-036 StallF=1 held for 10 cycles -> occupancy saturates at DEPTH=4, imem_req drops, head PCF frozen; release -> PCF sequence continues with no gap or duplicate.
REQ-037 Two outstanding (addrs 0x10,0x14), PCSrcE=1 with PCTargetE=0x102 -> next imem_addr=0x100; both stale responses dropped; first ValidF shows PCF=0x100.
REQ-038 imem_gnt=0 for 5 cycles -> imem_req=1 and imem_addr constant throughout; grant -> fpc advances by exactly 4.
REQ-039 Response and pop in the same cycle at occupancy 2 -> occupancy stays 2; ordering of PCF values preserved.
REQ-040 fpc=0xFFFFFFFC granted -> next imem_addr=0x00000000; head entry 0xFFFFFFFC shows PCPlus4F=0.
